// File: rtl/clock_core_gen.sv
// clock_core_gen: BCD time-of-day clock with validated load, keyed digit set with auto-repeat, and 12/24h hour display
module clock_core_gen #(
  parameter int RPT_DELAY = 500,
  parameter int RPT_PERIOD = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [1:0]  mode,
  input  logic [2:0]  pos,
  input  logic        inc,
  input  logic        dec,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        mode_12h,
  output logic [3:0]  sec_ones,
  output logic [2:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [2:0]  min_tens,
  output logic [3:0]  hour_ones,
  output logic [1:0]  hour_tens,
  output logic [3:0]  disp_hour_ones,
  output logic [1:0]  disp_hour_tens,
  output logic        pm,
  output logic        day_pulse
);
  localparam int CW = $clog2(RPT_DELAY + 1);
  function automatic logic [5:0] to_bcd(input logic [4:0] h);
    return h >= 5'd20 ? {2'd2, 4'(h - 5'd20)} : h >= 5'd10 ? {2'd1, 4'(h - 5'd10)} : {2'd0, h[3:0]};
  endfunction
  logic inc_q, dec_q, lock, lock_n, valid, fresh, step, lv, c1, c2, c3, c4, day_n;
  logic [2:0] pos_q;
  logic [1:0] mode_q;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] hr, hr_up, hr_dn, dh;
  logic [3:0] s1_n, m1_n, h1_n;
  logic [2:0] s10_n, m10_n;
  logic [1:0] h10_n;
  always_comb begin
    hr = 5'(hour_tens) * 5'd10 + 5'(hour_ones);
    hr_up = hr == 5'd23 ? 5'd0 : hr + 5'd1;
    hr_dn = hr == 5'd0 ? 5'd23 : hr - 5'd1;
    lv = load && load_time[3:0] <= 4'd9 && load_time[7:4] <= 4'd5 && load_time[11:8] <= 4'd9
         && load_time[15:12] <= 4'd5 && load_time[19:16] <= 4'd9
         && (load_time[23:20] < 4'd2 || (load_time[23:20] == 4'd2 && load_time[19:16] <= 4'd3));
    valid = mode == 2'b01 && pos != 3'd0 && pos != 3'd7 && (inc ^ dec) && !lock;
    fresh = valid && {inc_q, dec_q, pos_q, mode_q} != {inc, dec, pos, mode};
    step = fresh || (valid && cnt == CW'(RPT_DELAY));
    cnt_n = !valid ? '0 : fresh ? CW'(1) : cnt == CW'(RPT_DELAY) ? CW'(RPT_DELAY - RPT_PERIOD + 1) : cnt + CW'(1);
    lock_n = lock && (inc || dec);
    c1 = sec_ones == 4'd9;
    c2 = c1 && sec_tens == 3'd5;
    c3 = c2 && min_ones == 4'd9;
    c4 = c3 && min_tens == 3'd5;
    {h10_n, h1_n, m10_n, m1_n, s10_n, s1_n} = {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};
    day_n = 1'b0;
    if (lv)
      {h10_n, h1_n, m10_n, m1_n, s10_n, s1_n} = {load_time[21:20], load_time[19:16], load_time[14:12],
                                                 load_time[11:8], load_time[6:4], load_time[3:0]};
    else if (step) begin
      if (pos == 3'd6) s1_n = inc ? (c1 ? 4'd0 : sec_ones + 4'd1) : (sec_ones == 4'd0 ? 4'd9 : sec_ones - 4'd1);
      if (pos == 3'd5) s10_n = inc ? (sec_tens == 3'd5 ? 3'd0 : sec_tens + 3'd1) : (sec_tens == 3'd0 ? 3'd5 : sec_tens - 3'd1);
      if (pos == 3'd4) m1_n = inc ? (min_ones == 4'd9 ? 4'd0 : min_ones + 4'd1) : (min_ones == 4'd0 ? 4'd9 : min_ones - 4'd1);
      if (pos == 3'd3) m10_n = inc ? (min_tens == 3'd5 ? 3'd0 : min_tens + 3'd1) : (min_tens == 3'd0 ? 3'd5 : min_tens - 3'd1);
      if (pos == 3'd2) {h10_n, h1_n} = to_bcd(inc ? hr_up : hr_dn);
      if (pos == 3'd1) {h10_n, h1_n} = to_bcd(inc ? (hr >= 5'd14 ? hr - 5'd14 : hr + 5'd10)
                                                  : (hr < 5'd10 ? hr + 5'd14 : hr - 5'd10));
    end else if (tick && mode[1] == mode[0]) begin
      s1_n = c1 ? 4'd0 : sec_ones + 4'd1;
      s10_n = c2 ? 3'd0 : c1 ? sec_tens + 3'd1 : sec_tens;
      m1_n = c3 ? 4'd0 : c2 ? min_ones + 4'd1 : min_ones;
      m10_n = c4 ? 3'd0 : c3 ? min_tens + 3'd1 : min_tens;
      if (c4) {h10_n, h1_n} = to_bcd(hr_up);
      day_n = c4 && hr == 5'd23;
    end
    dh = !mode_12h ? hr : hr == 5'd0 ? 5'd12 : hr > 5'd12 ? hr - 5'd12 : hr;
    {disp_hour_tens, disp_hour_ones} = to_bcd(dh);
    pm = hr >= 5'd12;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones} <= '0;
      day_pulse <= 1'b0;
      {inc_q, dec_q, pos_q, mode_q} <= '0;
      cnt <= '0;
      lock <= inc | dec;
    end else begin
      {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones} <= {h10_n, h1_n, m10_n, m1_n, s10_n, s1_n};
      day_pulse <= day_n;
      {inc_q, dec_q, pos_q, mode_q} <= {inc, dec, pos, mode};
      cnt <= cnt_n;
      lock <= lock_n;
    end
  end
endmodule
